// File: rtl/rca_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rca_seq_ctrl : multi-precision add/subtract sequencer
//
// Purpose:
//   Performs WORDS*N-bit additions and subtractions using a single shared
//   N-bit ripple-carry adder. Operands are accepted through a valid/ready
//   handshake and processed one N-bit word per clock, least significant word
//   first. The carry is held in a register between words. The full-width
//   result, carry-out and signed overflow are returned through a second
//   valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start_valid  command and operands present
//   start_ready  controller can accept a command (IDLE only)
//   op_a, op_b   W-bit operands, sampled only at the accept edge
//   cin          carry-in for add mode, ignored when sub=1
//   sub          1: A - B computed as A + ~B + 1; 0: A + B + cin
//   res_valid    result, cout and overflow are valid (DONE)
//   res_ready    consumer takes the result
//   result       W-bit sum or difference
//   cout         carry out of the MSB (sub mode: 1 = no borrow)
//   overflow     two's-complement signed overflow
//   busy         high while in RUN or DONE
//
// Also contains rca, the purely combinational N-bit ripple-carry adder.
// ---------------------------------------------------------------------------

module rca #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  // One full adder per bit, with the carry rippling from bit 0 upward.
  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_carry[N];

endmodule

module rca_seq_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [N*WORDS-1:0] op_a,
  input  logic [N*WORDS-1:0] op_b,
  input  logic               cin,
  input  logic               sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N*WORDS-1:0] result,
  output logic               cout,
  output logic               overflow,
  output logic               busy
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [IW-1:0] IDX_ZERO = '0;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_overflow;
  logic          r_res_valid;
  logic          r_start_ready;
  logic          r_busy;

  logic [31:0]   w_base;
  logic [N-1:0]  w_a_word;
  logic [N-1:0]  w_b_word;
  logic [N-1:0]  w_sum;
  logic          w_cout;
  logic          w_last;

  // The word currently being worked on is selected by the index, so the
  // single narrow adder always sees word[index] of A and the effective B.
  assign w_base   = 32'(r_idx) * N;
  assign w_a_word = r_a[w_base +: N];
  assign w_b_word = r_b[w_base +: N];
  assign w_last   = (r_idx == IDX_LAST);

  rca #(.N(N)) u_rca (
    .a    (w_a_word),
    .b    (w_b_word),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Controller and datapath registers in one block. In IDLE the operands are
  // captured and B is inverted up front for subtraction, with the carry
  // preloaded to 1, so RUN only ever adds. RUN writes one result word per
  // edge and forwards the adder carry to the next word. On the last word the
  // carry-out and signed overflow are registered from the MSB word: overflow
  // happens when both MSBs agree but the sum MSB differs from them. DONE
  // holds everything stable until the consumer takes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_carry       <= 1'b0;
      r_idx         <= IDX_ZERO;
      r_result      <= '0;
      r_cout        <= 1'b0;
      r_overflow    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a           <= op_a;
            r_b           <= sub ? ~op_b : op_b;
            r_carry       <= sub ? 1'b1 : cin;
            r_idx         <= IDX_ZERO;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= RUN;
          end
        end
        RUN: begin
          r_result[w_base +: N] <= w_sum;
          r_carry               <= w_cout;
          if (w_last) begin
            r_cout      <= w_cout;
            r_overflow  <= (r_a[W-1] == r_b[W-1]) && (w_sum[N-1] != r_a[W-1]);
            r_idx       <= IDX_ZERO;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_res_valid   <= 1'b0;
          r_start_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_idx         <= IDX_ZERO;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign result      = r_result;
  assign cout        = r_cout;
  assign overflow    = r_overflow;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rca_seq_ctrl : self-checking bench for rca_seq_ctrl (N=4, WORDS=4)
//
// A transaction-level model predicts the handshake signals each cycle and
// the wide result from plain integer arithmetic; a compare process checks
// the DUT against it on every falling edge. Directed tests additionally pin
// hand-computed literal results and the accept-to-valid latency.
// ---------------------------------------------------------------------------

module tb_rca_seq_ctrl;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  // Transaction model state: cycles left until the result appears, whether
  // a result is waiting for the consumer, and the expected result fields.
  int           mCnt   = 0;
  bit           mValid = 1'b0;
  bit           mReady = 1'b1;
  logic [W-1:0] mRes   = '0;
  logic         mCout  = 1'b0;
  logic         mOvf   = 1'b0;

  rca_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update: a command is taken when idle, the result appears WORDS
  // edges later computed as one wide addition, and it is held until consumed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCnt   = 0;
      mValid = 1'b0;
      mReady = 1'b1;
      mRes   = '0;
      mCout  = 1'b0;
      mOvf   = 1'b0;
    end else if (mValid) begin
      if (res_ready) begin
        mValid = 1'b0;
        mReady = 1'b1;
      end
    end else if (mCnt > 0) begin
      mCnt--;
      if (mCnt == 0) mValid = 1'b1;
    end else if (start_valid) begin
      logic [W-1:0] bEff;
      logic [W:0]   full;
      bEff   = sub ? ~op_b : op_b;
      full   = {1'b0, op_a} + {1'b0, bEff} + (W+1)'(sub ? 1'b1 : cin);
      mRes   = full[W-1:0];
      mCout  = full[W];
      mOvf   = (op_a[W-1] == bEff[W-1]) && (full[W-1] != op_a[W-1]);
      mCnt   = WORDS;
      mReady = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkOn) begin
      chk("cyc_start_ready", 32'(start_ready), 32'(mReady));
      chk("cyc_res_valid", 32'(res_valid), 32'(mValid));
      chk("cyc_busy", 32'(busy), 32'((mCnt > 0) || mValid));
      if (mValid) begin
        chk("cyc_result", 32'(result), 32'(mRes));
        chk("cyc_cout", 32'(cout), 32'(mCout));
        chk("cyc_overflow", 32'(overflow), 32'(mOvf));
      end
    end
  end

  // Issue one command from a falling edge, then wait for res_valid while
  // scrambling the operand inputs; reports the accept-to-valid latency.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s);
    int lat;
    @(negedge clk);
    op_a        = a;
    op_b        = b;
    cin         = c;
    sub         = s;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    op_a        = ~a;
    op_b        = ~b;
    cin         = ~c;
    sub         = ~s;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(WORDS));
  endtask

  task automatic checkOutput(input string nm, input logic [W-1:0] expRes,
                             input logic expCout, input logic expOvf);
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_result"}, 32'(result), 32'(expRes));
    chk({nm, "_cout"}, 32'(cout), 32'(expCout));
    chk({nm, "_overflow"}, 32'(overflow), 32'(expOvf));
  endtask

  task automatic consumeResult();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_consume_ready", 32'(start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    res_ready   = 1'b0;
    #12;
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", {29'd0, res_valid, cout, overflow}, 32'd0);
    chk("reset_ready", 32'(start_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    checkOn = 1'b1;

    // Plain add
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    checkOutput("add_plain", 16'h5555, 1'b0, 1'b0);
    consumeResult();

    // Full carry ripple
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("ripple_b1", 16'h0000, 1'b1, 1'b0);
    consumeResult();
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    checkOutput("ripple_cin", 16'h0000, 1'b1, 1'b0);
    consumeResult();

    // Signed overflow in add mode
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("ovf_pos", 16'h8000, 1'b0, 1'b1);
    consumeResult();
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
    checkOutput("ovf_neg", 16'h0000, 1'b1, 1'b1);
    consumeResult();

    // Subtract, cin ignored
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    checkOutput("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
    consumeResult();
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    checkOutput("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    consumeResult();

    // Backpressure: new commands pulsed while the result is held
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i % 2 == 0);
      op_a        = 16'hAAAA + 16'(i);
      op_b        = 16'h5A5A;
      sub         = i[0];
      @(negedge clk);
      checkOutput("bp_hold", 16'h5555, 1'b0, 1'b0);
      chk("bp_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    consumeResult();
    applyStimulus(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    checkOutput("bp_next", 16'h1011, 1'b0, 1'b0);
    consumeResult();

    // Reset while index=2 in RUN
    @(negedge clk);
    op_a        = 16'h1234;
    op_b        = 16'h1111;
    cin         = 1'b0;
    sub         = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", {29'd0, res_valid, cout, overflow}, 32'd0);
    chk("midrst_ready", 32'(start_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
    checkOutput("post_rst", 16'h0100, 1'b0, 1'b0);
    consumeResult();

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
